// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first (copy until first one, invert after).
// Latency: input handshake at edge k -> VALID_O after edge k+WIDTH+1; one word in flight at a time.
// Backpressure: READY_I low outside IDLE; result held in DONE until READY_O completes the handshake.
module twos_to_signmag_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             VALID_I,
    output logic             READY_I,
    output logic [WIDTH-1:0] O,
    output logic             SIGN,
    output logic             VALID_O,
    input  logic             READY_O
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CW-1:0]    bit_cnt;
    logic             seen_one;
    logic             sign_reg;
    logic             cur_bit;
    logic             out_bit;
    logic             shift_done;

    // Negative words keep bits up to and including the first one, then invert.
    always_comb begin
        cur_bit    = shift_reg[0];
        out_bit    = (sign_reg && seen_one) ? ~cur_bit : cur_bit;
        shift_done = (bit_cnt == CW'(WIDTH));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (VALID_I)    state_nxt = SHIFT;
            SHIFT:   if (shift_done) state_nxt = DONE;
            DONE:    if (READY_O)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= IDLE;
            shift_reg  <= '0;
            result_reg <= '0;
            bit_cnt    <= '0;
            seen_one   <= 1'b0;
            sign_reg   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (VALID_I) begin
                        shift_reg <= I;
                        sign_reg  <= I[WIDTH-1];
                        seen_one  <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Bits enter at the MSB end so the LSB processed first lands in bit 0.
                    if (!shift_done) begin
                        result_reg <= {out_bit, result_reg[WIDTH-1:1]};
                        shift_reg  <= shift_reg >> 1;
                        bit_cnt    <= bit_cnt + CW'(1);
                        if (sign_reg) seen_one <= seen_one | cur_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign READY_I = RESETN && (state == IDLE);
    assign VALID_O = (state == DONE);
    assign O       = result_reg;
    assign SIGN    = sign_reg;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Bench for twos_to_signmag_serial: vector tables, backpressure and reset sequences, random scoreboard.
module tb_twos_to_signmag_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i8;
    logic       vi8, ri8, s8, vo8, ro8;
    logic [7:0] o8;
    logic [1:0] i2, o2;
    logic       vi2, ri2, s2, vo2, ro2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    twos_to_signmag_serial #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESETN(rst_n), .I(i8), .VALID_I(vi8), .READY_I(ri8),
        .O(o8), .SIGN(s8), .VALID_O(vo8), .READY_O(ro8)
    );

    twos_to_signmag_serial #(.WIDTH(2)) dut2 (
        .CLK(clk), .RESETN(rst_n), .I(i2), .VALID_I(vi2), .READY_I(ri2),
        .O(o2), .SIGN(s2), .VALID_O(vo2), .READY_O(ro2)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] mag;
        logic       sgn;
    } vec8_t;

    typedef struct {
        logic [1:0] din;
        logic [1:0] mag;
        logic       sgn;
    } vec2_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: absolute value and sign of the word read as a signed integer.
    function automatic logic [8:0] ref8(input logic [7:0] w);
        int v;
        v = int'($signed(w));
        if (v < 0) return {1'b1, 8'(-v)};
        return {1'b0, 8'(v)};
    endfunction

    // One word through the 8-bit instance with READY_O held high.
    task automatic send8(input logic [7:0] w, input logic [7:0] em, input logic es, input string nm);
        int n;
        ro8 = 1'b1;
        n = 0;
        while (!ri8 && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_ready_in"}, int'(ri8), 1);
        i8  = w;
        vi8 = 1'b1;
        @(posedge clk); #1;
        vi8 = 1'b0;
        i8  = 8'($urandom);
        chk({nm, "_busy"}, int'(ri8), 0);
        n = 0;
        while (!vo8 && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_o"}, int'(o8), int'(em));
        chk({nm, "_sign"}, int'(s8), int'(es));
        @(posedge clk); #1;
        chk({nm, "_idle_ready"}, int'(ri8), 1);
        chk({nm, "_idle_valid"}, int'(vo8), 0);
    endtask

    initial begin
        vec8_t      tbl8[6];
        vec2_t      tbl2[4];
        logic [7:0] exp_q[$];
        int         n;
        int         got;
        int         cyc;

        tbl8[0] = '{8'hFB, 8'h05, 1'b1};
        tbl8[1] = '{8'h05, 8'h05, 1'b0};
        tbl8[2] = '{8'h80, 8'h80, 1'b1};
        tbl8[3] = '{8'h00, 8'h00, 1'b0};
        tbl8[4] = '{8'hFF, 8'h01, 1'b1};
        tbl8[5] = '{8'h7F, 8'h7F, 1'b0};
        tbl2[0] = '{2'b00, 2'b00, 1'b0};
        tbl2[1] = '{2'b01, 2'b01, 1'b0};
        tbl2[2] = '{2'b10, 2'b10, 1'b1};
        tbl2[3] = '{2'b11, 2'b01, 1'b1};

        rst_n = 1'b0;
        i8 = '0; vi8 = 1'b1; ro8 = 1'b0;
        i2 = '0; vi2 = 1'b0; ro2 = 1'b0;
        #2;
        chk("reset_ready_in", int'(ri8), 0);
        chk("reset_valid_out", int'(vo8), 0);
        chk("reset_o", int'(o8), 0);
        chk("reset_sign", int'(s8), 0);
        vi8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready_in", int'(ri8), 1);

        // Single word and back-to-back words with the consumer always ready.
        for (int k = 0; k < 6; k++)
            send8(tbl8[k].din, tbl8[k].mag, tbl8[k].sgn, $sformatf("vec8_%0d", k));

        // Result held under backpressure while a new word is offered.
        ro8 = 1'b0;
        i8 = 8'h9C; vi8 = 1'b1;
        @(posedge clk); #1;
        i8 = 8'h11;
        n = 0;
        while (!vo8 && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_latency", n, 9);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_o_%0d", c), int'(o8), 8'h64);
            chk($sformatf("bp_sign_%0d", c), int'(s8), 1);
            chk($sformatf("bp_ready_in_%0d", c), int'(ri8), 0);
            chk($sformatf("bp_valid_%0d", c), int'(vo8), 1);
            @(posedge clk); #1;
        end
        ro8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready_in", int'(ri8), 1);
        @(posedge clk); #1;
        vi8 = 1'b0;
        chk("bp_second_busy", int'(ri8), 0);
        n = 0;
        while (!vo8 && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_second_latency", n, 9);
        chk("bp_second_o", int'(o8), 8'h11);
        chk("bp_second_sign", int'(s8), 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of shifting.
        i8 = 8'hC3; vi8 = 1'b1;
        @(posedge clk); #1;
        vi8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid_out", int'(vo8), 0);
        chk("arst_o", int'(o8), 0);
        chk("arst_sign", int'(s8), 0);
        chk("arst_ready_in", int'(ri8), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_ready_in", int'(ri8), 1);
        send8(8'hFE, 8'h02, 1'b1, "arst_next");

        // Two-bit instance, every input value.
        ro2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!ri2 && n < 20) begin @(posedge clk); #1; n++; end
            i2 = tbl2[k].din; vi2 = 1'b1;
            @(posedge clk); #1;
            vi2 = 1'b0;
            n = 0;
            while (!vo2 && n < 20) begin @(posedge clk); #1; n++; end
            chk($sformatf("w2_%0d_latency", k), n, 3);
            chk($sformatf("w2_%0d_o", k), int'(o2), int'(tbl2[k].mag));
            chk($sformatf("w2_%0d_sign", k), int'(s2), int'(tbl2[k].sgn));
            @(posedge clk); #1;
        end
        ro2 = 1'b0;

        // Random words with random input and output gaps against the reference.
        ro8 = 1'b0;
        fork
            begin
                logic [7:0] wd;
                int         wt;
                logic       acc;
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    wd = 8'($urandom);
                    i8 = wd; vi8 = 1'b1;
                    acc = 1'b0; wt = 0;
                    while (!acc && wt < 100) begin
                        if (ri8) begin acc = 1'b1; exp_q.push_back(wd); end
                        @(posedge clk); #1;
                        wt++;
                    end
                    vi8 = 1'b0;
                    i8  = 8'($urandom);
                    if (!acc) begin
                        chk("rand_accept", int'(acc), 1);
                        break;
                    end
                end
            end
            begin
                logic [7:0] w;
                logic [8:0] r;
                got = 0; cyc = 0;
                while (got < 1000 && cyc < 40000) begin
                    ro8 = ($urandom_range(0, 3) != 0);
                    if (vo8 && ro8) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rand_extra: got output 0x%0h, want no pending word", o8);
                        end else begin
                            w = exp_q.pop_front();
                            r = ref8(w);
                            chk($sformatf("rand_%0d_o", got), int'(o8), int'(r[7:0]));
                            chk($sformatf("rand_%0d_sign", got), int'(s8), int'(r[8]));
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                ro8 = 1'b0;
            end
        join
        chk("rand_count", got, 1000);
        chk("rand_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
